// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extracts and extends load data from the raw memory word,
// flags misaligned loads, and keeps a count of retired instructions.
module mem_wb_stage #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int FUNCT3_WIDTH  = 3,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     StallW,
    input  logic                     FlushW,
    input  logic                     ValidM,
    input  logic                     RegWriteM,
    input  logic [1:0]               ResultSrcM,
    input  logic [DATA_WIDTH-1:0]    ALUResultM,
    input  logic [DATA_WIDTH-1:0]    RD,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [DATA_WIDTH-1:0]    PCPlus4M,
    input  logic [FUNCT3_WIDTH-1:0]  funct3M,
    output logic                     ValidW,
    output logic                     RegWriteW,
    output logic [ADDRESS_WIDTH-1:0] RdW,
    output logic [DATA_WIDTH-1:0]    ResultW,
    output logic                     MisalignedW,
    output logic [CNT_WIDTH-1:0]     RetireCountW
);

    localparam logic [FUNCT3_WIDTH-1:0] F_LB  = FUNCT3_WIDTH'(0);
    localparam logic [FUNCT3_WIDTH-1:0] F_LH  = FUNCT3_WIDTH'(1);
    localparam logic [FUNCT3_WIDTH-1:0] F_LW  = FUNCT3_WIDTH'(2);
    localparam logic [FUNCT3_WIDTH-1:0] F_LBU = FUNCT3_WIDTH'(4);
    localparam logic [FUNCT3_WIDTH-1:0] F_LHU = FUNCT3_WIDTH'(5);

    logic [1:0]            w_off;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_mis;
    logic                  w_we;
    logic [DATA_WIDTH-1:0] w_load;

    logic                     r_valid;
    logic                     r_regwrite;
    logic [ADDRESS_WIDTH-1:0] r_rd;
    logic [1:0]               r_src;
    logic [DATA_WIDTH-1:0]    r_alu;
    logic [DATA_WIDTH-1:0]    r_load;
    logic [DATA_WIDTH-1:0]    r_pc4;
    logic                     r_mis;
    logic [CNT_WIDTH-1:0]     r_cnt;

    always_comb begin
        w_off  = ALUResultM[1:0];
        w_byte = RD[{w_off, 3'b000} +: 8];
        w_half = w_off[1] ? RD[31:16] : RD[15:0];

        // Misalignment only matters when the writeback actually selects load data.
        w_mis = 1'b0;
        if (ResultSrcM == 2'b01) begin
            case (funct3M)
                F_LH, F_LHU: w_mis = w_off[0];
                F_LW:        w_mis = (w_off != 2'b00);
                default:     w_mis = 1'b0;
            endcase
        end

        w_load = RD;
        if (!w_mis) begin
            case (funct3M)
                F_LB:    w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
                F_LH:    w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
                F_LBU:   w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
                F_LHU:   w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
                default: w_load = RD;
            endcase
        end

        w_we = RegWriteM & ValidM & (RdM != '0) & ~w_mis;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_src      <= 2'b00;
            r_alu      <= '0;
            r_load     <= '0;
            r_pc4      <= '0;
            r_mis      <= 1'b0;
            r_cnt      <= '0;
        end else if (FlushW) begin
            // Bubble: kill the control bits, leave the datapath registers as they were.
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_mis      <= 1'b0;
        end else if (!StallW) begin
            r_valid    <= ValidM;
            r_regwrite <= w_we;
            r_rd       <= RdM;
            r_src      <= ResultSrcM;
            r_alu      <= ALUResultM;
            r_load     <= w_load;
            r_pc4      <= PCPlus4M;
            r_mis      <= w_mis;
            if (ValidM) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        case (r_src)
            2'b00:   ResultW = r_alu;
            2'b01:   ResultW = r_load;
            2'b10:   ResultW = r_pc4;
            default: ResultW = '0;
        endcase
    end

    assign ValidW       = r_valid;
    assign RegWriteW    = r_regwrite;
    assign RdW          = r_rd;
    assign MisalignedW  = r_mis;
    assign RetireCountW = r_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/stall/flush/reset scenarios plus
// randomized traffic compared against a behavioural writeback model.
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallW, FlushW, ValidM, RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, RD, PCPlus4M;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;
    logic        ValidW, RegWriteW, MisalignedW;
    logic [4:0]  RdW;
    logic [31:0] ResultW, RetireCountW;

    logic        v4, rw4, mis4;
    logic [4:0]  rd4;
    logic [31:0] res4;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // expected W-stage state
    logic        e_valid, e_rw, e_mis, e_known;
    logic [4:0]  e_rd;
    logic [31:0] e_res, e_cnt;

    always #5 CLK = ~CLK;

    mem_wb_stage dut (
        .CLK(CLK), .RST_N(RST_N), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .RD(RD),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .funct3M(funct3M), .ValidW(ValidW),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .MisalignedW(MisalignedW),
        .RetireCountW(RetireCountW)
    );

    mem_wb_stage #(.CNT_WIDTH(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .StallW(StallW), .FlushW(FlushW), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .RD(RD),
        .RdM(RdM), .PCPlus4M(PCPlus4M), .funct3M(funct3M), .ValidW(v4),
        .RegWriteW(rw4), .RdW(rd4), .ResultW(res4), .MisalignedW(mis4),
        .RetireCountW(cnt4)
    );

    // Reference: what a load of this type at this address delivers, and whether it is misaligned.
    function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] src, input logic [31:0] addr);
        int off = int'(addr % 4);
        if (src != 2'd1) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
        if (f3 == 3'd2) return off != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] src,
                                              input logic [31:0] addr, input logic [31:0] word);
        int off = int'(addr % 4);
        logic [7:0]  b = 8'(word >> (8 * off));
        logic [15:0] h = 16'(word >> (16 * (off / 2)));
        if (ref_mis(f3, src, addr)) return word;
        case (f3)
            3'd0:    return 32'($signed(b));
            3'd1:    return 32'($signed(h));
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return word;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        if (FlushW) begin
            e_valid = 0; e_rw = 0; e_mis = 0; e_known = 0;
        end else if (!StallW) begin
            e_valid = ValidM;
            e_mis   = ref_mis(funct3M, ResultSrcM, ALUResultM);
            e_rw    = RegWriteM && ValidM && RdM != 0 && !e_mis;
            e_rd    = RdM;
            case (ResultSrcM)
                2'd0: e_res = ALUResultM;
                2'd1: e_res = ref_load(funct3M, ResultSrcM, ALUResultM, RD);
                2'd2: e_res = PCPlus4M;
                default: e_res = 0;
            endcase
            e_known = 1;
            if (ValidM) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] rd_word, input logic [4:0] rd, input logic [31:0] pc4,
                         input logic [2:0] f3);
        ValidM = v; RegWriteM = rw; ResultSrcM = src; ALUResultM = alu;
        RD = rd_word; RdM = rd; PCPlus4M = pc4; funct3M = f3;
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 0; StallW = 0; FlushW = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        e_valid = 0; e_rw = 0; e_mis = 0; e_rd = 0; e_res = 0; e_cnt = 0; e_known = 1;
        repeat (2) @(posedge CLK);
        #2 RST_N = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ValidW !== 0)       begin n_fail++; $display("FAIL reset_valid got=%0d exp=0", ValidW); end
        n_checks++; if (RegWriteW !== 0)    begin n_fail++; $display("FAIL reset_regwrite got=%0d exp=0", RegWriteW); end
        n_checks++; if (RdW !== 0)          begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", RdW); end
        n_checks++; if (ResultW !== 0)      begin n_fail++; $display("FAIL reset_result got=%h exp=0", ResultW); end
        n_checks++; if (MisalignedW !== 0)  begin n_fail++; $display("FAIL reset_mis got=%0d exp=0", MisalignedW); end
        n_checks++; if (RetireCountW !== 0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", RetireCountW); end
    endtask

    task automatic test_lb();
        drive(1, 1, 2'b01, 32'h1001, 32'h80FF7F01, 5'd5, 32'h44, 3'b000);
        tick();
        n_checks++; if (ResultW !== 32'h0000007F) begin n_fail++; $display("FAIL lb_result got=%h exp=0000007f", ResultW); end
        n_checks++; if (RdW !== 5'd5)             begin n_fail++; $display("FAIL lb_rd got=%0d exp=5", RdW); end
        n_checks++; if (RegWriteW !== 1'b1)       begin n_fail++; $display("FAIL lb_regwrite got=%0d exp=1", RegWriteW); end
    endtask

    task automatic test_lh();
        drive(1, 1, 2'b01, 32'h2002, 32'h80FF0000, 5'd6, 32'h48, 3'b101);
        tick();
        n_checks++; if (ResultW !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_result got=%h exp=000080ff", ResultW); end
        drive(1, 1, 2'b01, 32'h2002, 32'h80FF0000, 5'd6, 32'h4C, 3'b001);
        tick();
        n_checks++; if (ResultW !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_result got=%h exp=ffff80ff", ResultW); end
        n_checks++; if (MisalignedW !== 1'b0)     begin n_fail++; $display("FAIL lh_mis got=%0d exp=0", MisalignedW); end
    endtask

    task automatic test_misaligned();
        drive(1, 1, 2'b01, 32'h3001, 32'hDEADBEEF, 5'd7, 32'h50, 3'b010);
        tick();
        n_checks++; if (MisalignedW !== 1'b1)     begin n_fail++; $display("FAIL mislw_flag got=%0d exp=1", MisalignedW); end
        n_checks++; if (RegWriteW !== 1'b0)       begin n_fail++; $display("FAIL mislw_regwrite got=%0d exp=0", RegWriteW); end
        n_checks++; if (ResultW !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mislw_result got=%h exp=deadbeef", ResultW); end
        // same offset on an ALU op is not a misaligned load
        drive(1, 1, 2'b00, 32'h3001, 32'hDEADBEEF, 5'd7, 32'h54, 3'b010);
        tick();
        n_checks++; if (MisalignedW !== 1'b0)     begin n_fail++; $display("FAIL alu_mis got=%0d exp=0", MisalignedW); end
        n_checks++; if (ResultW !== 32'h3001)     begin n_fail++; $display("FAIL alu_result got=%h exp=00003001", ResultW); end
    endtask

    task automatic test_x0_stall();
        logic [31:0] cnt0;
        drive(1, 1, 2'b10, 32'h1234, 32'h0, 5'd0, 32'h100, 3'b010);
        tick();
        n_checks++; if (RegWriteW !== 1'b0) begin n_fail++; $display("FAIL x0_regwrite got=%0d exp=0", RegWriteW); end
        n_checks++; if (ValidW !== 1'b1)    begin n_fail++; $display("FAIL x0_valid got=%0d exp=1", ValidW); end
        n_checks++; if (ResultW !== 32'h100) begin n_fail++; $display("FAIL x0_result got=%h exp=00000100", ResultW); end
        cnt0 = e_cnt;
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 2'b00, $urandom, $urandom, 5'd9, $urandom, 3'b000);
            tick();
            n_checks++; if (ValidW !== 1'b1 || RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultW !== 32'h100)
                begin n_fail++; $display("FAIL stall_hold cyc=%0d got v=%0d rw=%0d rd=%0d res=%h exp v=1 rw=0 rd=0 res=00000100", i, ValidW, RegWriteW, RdW, ResultW); end
            n_checks++; if (RetireCountW !== cnt0)
                begin n_fail++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", i, RetireCountW, cnt0); end
        end
        StallW = 0;
    endtask

    task automatic test_flush_stall();
        logic [31:0] cnt0;
        drive(1, 1, 2'b01, 32'h1, 32'h0, 5'd3, 32'h0, 3'b010);
        tick();
        cnt0 = e_cnt;
        StallW = 1; FlushW = 1;
        drive(1, 1, 2'b00, 32'h55, 32'h0, 5'd4, 32'h0, 3'b000);
        tick();
        n_checks++; if (ValidW !== 0 || RegWriteW !== 0 || MisalignedW !== 0)
            begin n_fail++; $display("FAIL flushstall_ctrl got v=%0d rw=%0d mis=%0d exp 0 0 0", ValidW, RegWriteW, MisalignedW); end
        n_checks++; if (RetireCountW !== cnt0)
            begin n_fail++; $display("FAIL flushstall_cnt got=%0d exp=%0d", RetireCountW, cnt0); end
        StallW = 0; FlushW = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 2'b00, i, 0, 5'd1, 0, 3'b000);
            tick();
        end
        n_checks++; if (cnt4 !== 4'd1)          begin n_fail++; $display("FAIL wrap_cnt4 got=%0d exp=1", cnt4); end
        n_checks++; if (RetireCountW !== 32'd17) begin n_fail++; $display("FAIL wrap_cnt32 got=%0d exp=17", RetireCountW); end
    endtask

    task automatic test_random();
        logic [2:0] f3s [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int i = 0; i < 300; i++) begin
            FlushW = ($urandom_range(0, 9) == 0);
            StallW = ($urandom_range(0, 6) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
                  $urandom, $urandom, 5'($urandom_range(0, 7)), $urandom, f3s[$urandom_range(0, 7)]);
            tick();
            n_checks++; if (ValidW !== e_valid || RegWriteW !== e_rw || MisalignedW !== e_mis)
                begin n_fail++; $display("FAIL rnd_ctrl cyc=%0d got v=%0d rw=%0d mis=%0d exp v=%0d rw=%0d mis=%0d", i, ValidW, RegWriteW, MisalignedW, e_valid, e_rw, e_mis); end
            if (e_known) begin
                n_checks++; if (RdW !== e_rd || ResultW !== e_res)
                    begin n_fail++; $display("FAIL rnd_data cyc=%0d got rd=%0d res=%h exp rd=%0d res=%h", i, RdW, ResultW, e_rd, e_res); end
            end
            n_checks++; if (RetireCountW !== e_cnt || cnt4 !== e_cnt[3:0])
                begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, RetireCountW, cnt4, e_cnt, e_cnt[3:0]); end
        end
        StallW = 0; FlushW = 0;
    endtask

    task automatic test_async_reset();
        drive(1, 1, 2'b10, 32'h0, 32'h0, 5'd8, 32'hABCD, 3'b000);
        StallW = 1;
        tick();
        StallW = 0;
        tick();
        #2 RST_N = 0;
        #1;
        n_checks++; if (ValidW !== 0 || RegWriteW !== 0 || RdW !== 0 || ResultW !== 0 || MisalignedW !== 0 || RetireCountW !== 0)
            begin n_fail++; $display("FAIL async_reset got v=%0d rw=%0d rd=%0d res=%h mis=%0d cnt=%0d exp all 0", ValidW, RegWriteW, RdW, ResultW, MisalignedW, RetireCountW); end
        @(posedge CLK); #1;
        n_checks++; if (ValidW !== 0 || RetireCountW !== 0)
            begin n_fail++; $display("FAIL reset_held got v=%0d cnt=%0d exp 0 0", ValidW, RetireCountW); end
        #2 RST_N = 1;
        e_valid = 0; e_rw = 0; e_mis = 0; e_rd = 0; e_res = 0; e_cnt = 0; e_known = 1;
        #1;
        n_checks++; if (ValidW !== 0 || RetireCountW !== 0)
            begin n_fail++; $display("FAIL release_before_edge got v=%0d cnt=%0d exp 0 0", ValidW, RetireCountW); end
        tick();
        n_checks++; if (ValidW !== 1 || RetireCountW !== 1 || ResultW !== 32'hABCD)
            begin n_fail++; $display("FAIL first_after_reset got v=%0d cnt=%0d res=%h exp 1 1 0000abcd", ValidW, RetireCountW, ResultW); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lh();
        test_misaligned();
        test_x0_stall();
        test_flush_stall();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning datapath width; only 32 is supported.
REQ-003 The block SHALL have parameter FUNCT3_WIDTH, default 3, meaning load-type field width.
REQ-004 The block SHALL have parameter CNT_WIDTH, default 32, meaning retire-counter width.
REQ-005 The block SHALL use one clock, CLK, and an asynchronous active-low reset, RST_N.
REQ-006 The block SHALL have the following ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  async active-low reset
- StallW  in  1  hold all W registers
- FlushW  in  1  insert bubble
- ValidM  in  1  M-stage holds a real instruction
- RegWriteM  in  1  register-write enable
- ResultSrcM  in  2  result select
- ALUResultM  in  DATA_WIDTH  ALU result / load address
- RD  in  DATA_WIDTH  raw data-memory word
- RdM  in  ADDRESS_WIDTH  destination register
- PCPlus4M  in  DATA_WIDTH  PC+4
- funct3M  in  FUNCT3_WIDTH  load type
- ValidW  out  1  W-stage holds a real instruction
- RegWriteW  out  1  qualified write enable
- RdW  out  ADDRESS_WIDTH  destination register
- ResultW  out  DATA_WIDTH  selected writeback value, combinational from W registers
- MisalignedW  out  1  registered misaligned-load flag
- RetireCountW  out  CNT_WIDTH  retired-instruction count

Function
REQ-007 Load extraction SHALL be combinational on M-side inputs and its result registered, using off = ALUResultM[1:0]:
- 000 LB: sign-extend byte off
- 001 LH: sign-extend half off[1]
- 010 LW: full word
- 100 LBU: zero-extend byte off
- 101 LHU: zero-extend half off[1]
- other codes: full word
REQ-008 Misalignment SHALL be defined as LH/LHU with off[0]=1, or LW with off!=0; it SHALL be computed only when ResultSrcM=01; when set, the registered load data SHALL be the raw RD.
REQ-009 The qualified write enable SHALL be RegWriteM & ValidM & (RdM!=0) & ~misaligned.
REQ-010 Register update priority SHALL be flush, then stall, then load, evaluated per rising CLK:
- FlushW=1: ValidW, RegWriteW and MisalignedW SHALL be 0; the other registers SHALL be don't-care but held.
- StallW=1 and FlushW=0: all W registers SHALL hold.
- Otherwise: all W registers SHALL load M values; ValidW SHALL take ValidM.
REQ-011 ResultW SHALL be selected by the registered ResultSrc:
- 00: ALUResult
- 01: extended load data
- 10: PCPlus4
- 11: 0
REQ-012 Latency SHALL be one cycle from M inputs to W outputs.
REQ-013 RetireCountW SHALL increment by 1 on each edge where FlushW=0, StallW=0 and ValidM=1.
REQ-014 RetireCountW SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-015 Stall or flush SHALL never increment RetireCountW.
REQ-016 FlushW and StallW asserted together SHALL behave as flush.

Reset
REQ-017 While RST_N=0, all W registers and RetireCountW SHALL be 0 immediately, independent of CLK; ResultW is therefore 0.
REQ-018 Deassertion of RST_N SHALL take effect at the next rising CLK.
REQ-019 Reset asserted mid-stall or mid-flush SHALL override both.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- LB: RD=0x80FF7F01, ALUResultM=0x1001, funct3=000, ResultSrc=01, valid, RegWrite, Rd=5 -> next cycle ResultW=0x0000007F, RdW=5, RegWriteW=1.
- LHU and LH: RD=0x80FF0000, addr offset 2 -> LHU: ResultW=0x000080FF; LH: ResultW=0xFFFF80FF.
- Misaligned LW: offset 1 -> MisalignedW=1, RegWriteW=0, ResultW=RD.
- x0 and stall: write to x0 -> RegWriteW=0 with ValidW=1; StallW held 3 cycles -> all outputs frozen, count unchanged.
- Flush plus stall together: ValidW=0, RegWriteW=0, count unchanged; CNT_WIDTH=4 with 17 valid retires -> RetireCountW=1.
- Async reset: RST_N low mid-cycle -> outputs 0 before the next edge.
